// File: rtl/l0_flush_pkg.sv
// Purpose: shared types and constants for the L0 fetch-buffer flush sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package l0_flush_pkg;

  // Sequencer states: idle/accepting, driving flush lines, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Default abort bound, in FLUSH-state cycles.
  localparam int unsigned L0_FLUSH_TIMEOUT_DEF = 255;

  // Width of each per-core fetch-stall counter (shared with the register map).
  localparam int unsigned L0_STALL_CNT_W = 32;

endpackage

// File: rtl/l0_stall_sum.sv
// Purpose: saturating sum of the per-core stall counters selected by a mask.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   mask_i  cores whose counter contributes to the sum
//   cnt_i   packed per-core counters, core i at [i*CNT_W +: CNT_W]
//   sum_o   sum clamped to all-ones when it does not fit in CNT_W bits
module l0_stall_sum #(
  parameter int unsigned NB_CORES = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic [NB_CORES-1:0]       mask_i,
  input  logic [NB_CORES*CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0]          sum_o
);

  // Wide enough that adding NB_CORES full-scale counters can never wrap.
  localparam int unsigned SUM_W = CNT_W + $clog2(NB_CORES);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [SUM_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (mask_i[i]) begin
        acc = acc + SUM_W'(cnt_i[i*CNT_W +: CNT_W]);
      end
    end
    sum_o = (acc > CNT_MAX) ? {CNT_W{1'b1}} : acc[CNT_W-1:0];
  end

endmodule

// File: rtl/l0_flush_ctrl.sv
// Purpose: sequences the per-core L0 fetch-buffer flush handshake with a bounded wait.
// Latency: accept-to-done 1 cycle (empty mask), 2 cycles minimum otherwise, TIMEOUT_CYCLES+1 on abort.
// Backpressure: req_ready_o is high only in IDLE; requests are held off while busy, never queued.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/_ready_o/req_mask_i  flush request handshake and core selection
//   flush_o, flush_ack_i            per-core flush level and its acknowledge
//   stall_count_i                   packed per-core fetch-stall counters
//   busy_o, done_o, timeout_o       status: FLUSH|DONE, completion pulse, sticky abort flag
//   pending_o                       cores still unacknowledged (frozen after an abort)
//   stall_sum_o                     saturated stall-count sum over the accepted mask
module l0_flush_ctrl
  import l0_flush_pkg::*;
#(
  parameter int unsigned NB_CORES       = 8,
  parameter int unsigned TIMEOUT_CYCLES = L0_FLUSH_TIMEOUT_DEF,
  parameter int unsigned CNT_W          = L0_STALL_CNT_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [NB_CORES-1:0]       req_mask_i,
  output logic [NB_CORES-1:0]       flush_o,
  input  logic [NB_CORES-1:0]       flush_ack_i,
  input  logic [NB_CORES*CNT_W-1:0] stall_count_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      timeout_o,
  output logic [NB_CORES-1:0]       pending_o,
  output logic [CNT_W-1:0]          stall_sum_o
);

  // Timer only has to count up to TIMEOUT_CYCLES-1.
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [NB_CORES-1:0]  mask_q, mask_d;
  logic [NB_CORES-1:0]  pending_q, pending_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_W-1:0]     sum_q, sum_d;
  logic [NB_CORES-1:0]  pend_nxt;
  logic [CNT_W-1:0]     sum_w;

  l0_stall_sum #(
    .NB_CORES (NB_CORES),
    .CNT_W    (CNT_W)
  ) u_stall_sum (
    .mask_i (mask_q),
    .cnt_i  (stall_count_i),
    .sum_o  (sum_w)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      sum_q     <= sum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    pending_d   = pending_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    sum_d       = sum_q;
    req_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    flush_o     = '0;
    // Masking by pending_q means acks on idle or already-cleared cores are ignored.
    pend_nxt    = pending_q & ~flush_ack_i;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          mask_d    = req_mask_i;
          pending_d = req_mask_i;
          timer_d   = '0;
          timeout_d = 1'b0;
          state_d   = (|req_mask_i) ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        busy_o    = 1'b1;
        flush_o   = pending_q;
        pending_d = pend_nxt;
        // Completion wins over an abort landing on the same cycle.
        if (pend_nxt == '0) begin
          state_d = DONE;
        end else if (timer_q == TMR_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        sum_d   = sum_w;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_o   = pending_q;
  assign timeout_o   = timeout_q;
  assign stall_sum_o = sum_q;

endmodule
